// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises the raw pins, deserialises R/W + addr + data frames
// and emits a single write strobe per well-formed write frame, or an error pulse otherwise.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nCS,
    input  logic              SCLK,
    input  logic              COPI,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state_q;
    logic [SYNC_STAGES-1:0]  ncsSync_q;
    logic [SYNC_STAGES-1:0]  sclkSync_q;
    logic [SYNC_STAGES-1:0]  copiSync_q;
    logic                    ncsPrev_q;
    logic                    sclkPrev_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]        count_q;
    logic                    startPend_q;
    logic                    wrValid_q;
    logic                    frameErr_q;
    logic [ADDR_W-1:0]       wrAddr_q;
    logic [DATA_W-1:0]       wrData_q;

    logic ncsS;
    logic sclkS;
    logic copiS;
    logic sclkRise;
    logic csFall;
    logic csRise;

    assign ncsS     = ncsSync_q[SYNC_STAGES-1];
    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign copiS    = copiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign csFall   = ~ncsS & ncsPrev_q;
    assign csRise   = ncsS & ~ncsPrev_q;

    // Synchronisers, edge detectors, deserialiser and frame FSM share one clocked process.
    // A cs_fall landing in DONE is remembered so IDLE can start the next frame a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ncsSync_q   <= '1;
            sclkSync_q  <= '0;
            copiSync_q  <= '0;
            ncsPrev_q   <= 1'b1;
            sclkPrev_q  <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
            startPend_q <= 1'b0;
            wrValid_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            state_q     <= IDLE;
        end else begin
            ncsSync_q   <= {ncsSync_q[SYNC_STAGES-2:0], nCS};
            sclkSync_q  <= {sclkSync_q[SYNC_STAGES-2:0], SCLK};
            copiSync_q  <= {copiSync_q[SYNC_STAGES-2:0], COPI};
            ncsPrev_q   <= ncsS;
            sclkPrev_q  <= sclkS;
            wrValid_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            startPend_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (csFall || startPend_q) begin
                        count_q <= '0;
                        shift_q <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (csRise) begin
                        state_q <= DONE;
                    end else if (sclkRise && !ncsS) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], copiS};
                        if (count_q != CNT_MAX) begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    startPend_q <= csFall;
                    if (count_q == CNT_FULL) begin
                        if (shift_q[FRAME_BITS-1]) begin
                            wrValid_q <= 1'b1;
                            wrAddr_q  <= shift_q[FRAME_BITS-2 -: ADDR_W];
                            wrData_q  <= shift_q[DATA_W-1:0];
                        end
                    end else begin
                        frameErr_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_valid  = wrValid_q;
    assign frame_err = frameErr_q;
    assign wr_addr   = wrAddr_q;
    assign wr_data   = wrData_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: frames are bit-banged at clk/8 into a 2-stage and a 3-stage instance.
module tb_spi_frame_rx;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       nCS  = 1'b1;
    logic       SCLK = 1'b0;
    logic       COPI = 1'b0;

    logic       wr_valid, frame_err, busy;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       wrValid3, frameErr3, busy3;
    logic [6:0] wrAddr3;
    logic [7:0] wrData3;

    int checks   = 0;
    int failures = 0;

    int         validCycles = 0;
    int         errCycles   = 0;
    int         bothCycles  = 0;
    logic [6:0] capAddr [8];
    logic [7:0] capData [8];

    spi_frame_rx #(.SYNC_STAGES(2), .ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .busy(busy)
    );

    spi_frame_rx #(.SYNC_STAGES(3), .ADDR_W(7), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
        .wr_valid(wrValid3), .wr_addr(wrAddr3), .wr_data(wrData3),
        .frame_err(frameErr3), .busy(busy3)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles of each strobe and logs every written addr/data pair.
    always @(negedge clk) begin
        if (wr_valid) begin
            if (validCycles < 8) begin
                capAddr[validCycles] = wr_addr;
                capData[validCycles] = wr_data;
            end
            validCycles = validCycles + 1;
        end
        if (frame_err) errCycles = errCycles + 1;
        if (wr_valid && frame_err) bothCycles = bothCycles + 1;
    end

    task automatic sendBits(input logic [31:0] bits, input int n);
        nCS = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            COPI = bits[n-1-i];
            SCLK = 1'b0;
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        SCLK = 1'b0;
        COPI = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [31:0] bits, input int n, input int gap);
        sendBits(bits, n);
        nCS = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wr_valid !== 1'b0)   begin failures++; $display("[TB] FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (frame_err !== 1'b0)  begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (wr_addr !== 7'h00)   begin failures++; $display("[TB] FAIL reset_addr got=%h exp=00", wr_addr); end
        checks++; if (wr_data !== 8'h00)   begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", wr_data); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        sendBits(32'h8455, 16);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL write_busy_mid got=%b exp=1", busy); end
        nCS = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (validCycles - v0 !== 1) begin failures++; $display("[TB] FAIL write_valid_cycles got=%0d exp=1", validCycles - v0); end
        checks++; if (errCycles - e0 !== 0)   begin failures++; $display("[TB] FAIL write_err_cycles got=%0d exp=0", errCycles - e0); end
        checks++; if (wr_addr !== 7'h04)      begin failures++; $display("[TB] FAIL write_addr got=%h exp=04", wr_addr); end
        checks++; if (wr_data !== 8'h55)      begin failures++; $display("[TB] FAIL write_data got=%h exp=55", wr_data); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("[TB] FAIL write_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_read;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        sendFrame(32'h0455, 16, 12);
        checks++; if (validCycles - v0 !== 0) begin failures++; $display("[TB] FAIL read_valid_cycles got=%0d exp=0", validCycles - v0); end
        checks++; if (errCycles - e0 !== 0)   begin failures++; $display("[TB] FAIL read_err_cycles got=%0d exp=0", errCycles - e0); end
        checks++; if (wr_addr !== 7'h04)      begin failures++; $display("[TB] FAIL read_addr got=%h exp=04", wr_addr); end
        checks++; if (wr_data !== 8'h55)      begin failures++; $display("[TB] FAIL read_data got=%h exp=55", wr_data); end
    endtask

    task automatic test_short;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        sendFrame(32'h0000_0ABC, 12, 12);
        checks++; if (errCycles - e0 !== 1)   begin failures++; $display("[TB] FAIL short_err_cycles got=%0d exp=1", errCycles - e0); end
        checks++; if (validCycles - v0 !== 0) begin failures++; $display("[TB] FAIL short_valid_cycles got=%0d exp=0", validCycles - v0); end
        checks++; if (wr_addr !== 7'h04)      begin failures++; $display("[TB] FAIL short_addr got=%h exp=04", wr_addr); end
        checks++; if (wr_data !== 8'h55)      begin failures++; $display("[TB] FAIL short_data got=%h exp=55", wr_data); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("[TB] FAIL short_busy got=%b exp=0", busy); end
    endtask

    task automatic test_overflow;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        sendFrame(32'h0001_0354, 17, 12);
        checks++; if (errCycles - e0 !== 1)   begin failures++; $display("[TB] FAIL overflow_err_cycles got=%0d exp=1", errCycles - e0); end
        checks++; if (validCycles - v0 !== 0) begin failures++; $display("[TB] FAIL overflow_valid_cycles got=%0d exp=0", validCycles - v0); end
        checks++; if (wr_addr !== 7'h04)      begin failures++; $display("[TB] FAIL overflow_addr got=%h exp=04", wr_addr); end
    endtask

    task automatic test_reset_midframe;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        sendBits(32'h0000_0082, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nCS = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (validCycles - v0 !== 0) begin failures++; $display("[TB] FAIL midrst_valid_cycles got=%0d exp=0", validCycles - v0); end
        checks++; if (errCycles - e0 !== 0)   begin failures++; $display("[TB] FAIL midrst_err_cycles got=%0d exp=0", errCycles - e0); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (wr_addr !== 7'h00)      begin failures++; $display("[TB] FAIL midrst_addr_cleared got=%h exp=00", wr_addr); end
        sendFrame(32'h8112, 16, 12);
        checks++; if (validCycles - v0 !== 1) begin failures++; $display("[TB] FAIL midrst_next_valid got=%0d exp=1", validCycles - v0); end
        checks++; if (wr_addr !== 7'h01)      begin failures++; $display("[TB] FAIL midrst_next_addr got=%h exp=01", wr_addr); end
        checks++; if (wr_data !== 8'h12)      begin failures++; $display("[TB] FAIL midrst_next_data got=%h exp=12", wr_data); end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        sendFrame(32'h80FF, 16, 4);
        sendFrame(32'h8380, 16, 12);
        checks++; if (validCycles - v0 !== 2) begin failures++; $display("[TB] FAIL b2b_valid_cycles got=%0d exp=2", validCycles - v0); end
        checks++; if (errCycles - e0 !== 0)   begin failures++; $display("[TB] FAIL b2b_err_cycles got=%0d exp=0", errCycles - e0); end
        if (v0 + 1 < 8) begin
            checks++; if (capAddr[v0] !== 7'h00 || capData[v0] !== 8'hFF)
                begin failures++; $display("[TB] FAIL b2b_first got=%h/%h exp=00/ff", capAddr[v0], capData[v0]); end
            checks++; if (capAddr[v0+1] !== 7'h03 || capData[v0+1] !== 8'h80)
                begin failures++; $display("[TB] FAIL b2b_second got=%h/%h exp=03/80", capAddr[v0+1], capData[v0+1]); end
        end
        checks++; if (wr_addr !== 7'h03 || wr_data !== 8'h80)
            begin failures++; $display("[TB] FAIL b2b_final got=%h/%h exp=03/80", wr_addr, wr_data); end
    endtask

    task automatic test_reset_low;
        int v0, e0;
        v0 = validCycles; e0 = errCycles;
        nCS = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        nCS = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (errCycles - e0 !== 1)   begin failures++; $display("[TB] FAIL rstlow_err_cycles got=%0d exp=1", errCycles - e0); end
        checks++; if (validCycles - v0 !== 0) begin failures++; $display("[TB] FAIL rstlow_valid_cycles got=%0d exp=0", validCycles - v0); end
    endtask

    task automatic test_latency;
        int lat2, lat3;
        lat2 = -1; lat3 = -1;
        sendBits(32'h8455, 16);
        nCS = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (wr_valid && lat2 < 0) lat2 = e - 1;
            if (wrValid3 && lat3 < 0) lat3 = e - 1;
        end
        checks++; if (lat2 !== 3) begin failures++; $display("[TB] FAIL latency_sync2 got=%0d exp=3", lat2); end
        checks++; if (lat3 !== 4) begin failures++; $display("[TB] FAIL latency_sync3 got=%0d exp=4", lat3); end
        checks++; if (wrAddr3 !== 7'h04 || wrData3 !== 8'h55)
            begin failures++; $display("[TB] FAIL sync3_write got=%h/%h exp=04/55", wrAddr3, wrData3); end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_write();
        test_read();
        test_short();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        test_reset_low();
        test_latency();
        checks++; if (bothCycles !== 0) begin failures++; $display("[TB] FAIL valid_err_overlap got=%0d exp=0", bothCycles); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
